// File: rtl/phy_ctrl_mux.sv
// phy_ctrl_mux: routes one of NumCtrl controller channels onto a shared PHY, switching only after a bus-free wait and a released-bus guard (optional PHY_CTRL_MUX_FORCE_SW_EN adds force_sw_i to skip the bus-free wait)
module phy_ctrl_mux #(
    parameter int NumCtrl     = 4,
    parameter int SelW        = $clog2(NumCtrl),
    parameter int TimerW      = 20,
    parameter int GuardCycles = 4,
    parameter int ResetSel    = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                scl_i,
    input  logic                sda_i,
    output logic                scl_o,
    output logic                sda_o,
    output logic                sel_od_pp_o,
    output logic [NumCtrl-1:0]  ctrl_scl_o,
    output logic [NumCtrl-1:0]  ctrl_sda_o,
    input  logic [NumCtrl-1:0]  ctrl_scl_i,
    input  logic [NumCtrl-1:0]  ctrl_sda_i,
    input  logic [NumCtrl-1:0]  ctrl_sel_od_pp_i,
    input  logic [SelW-1:0]     sel_req_i,
    input  logic                sel_req_valid_i,
    output logic                sel_req_ready_o,
    input  logic [TimerW-1:0]   t_bus_free_i,
`ifdef PHY_CTRL_MUX_FORCE_SW_EN
    input  logic                force_sw_i,
`endif
    output logic [SelW-1:0]     sel_active_o,
    output logic                switching_o,
    output logic                switch_done_o,
    output logic                err_sel_o
);
    typedef enum logic [1:0] {ACTIVE, WAIT_FREE, GUARD} state_t;
    localparam logic [SelW:0] num_ctrl   = (SelW+1)'(NumCtrl);
    localparam logic [7:0]    guard_last = 8'(GuardCycles - 1);
    state_t            state_q, state_d;
    logic [SelW-1:0]   sel_d, pend_q, pend_d;
    logic [TimerW-1:0] cnt_q, cnt_d;
    logic [7:0]        gcnt_q, gcnt_d;
    logic              done_d, err_d, force_en, accept, bad_sel, bus_idle;
`ifdef PHY_CTRL_MUX_FORCE_SW_EN
    assign force_en = force_sw_i;
`else
    assign force_en = 1'b0;
`endif
    assign sel_req_ready_o = state_q == ACTIVE;
    assign switching_o     = state_q != ACTIVE;
    assign accept          = sel_req_valid_i && sel_req_ready_o;
    assign bad_sel         = {1'b0, sel_req_i} >= num_ctrl;
    assign bus_idle        = scl_i && sda_i;
    // state, selection and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ACTIVE;
            sel_active_o  <= SelW'(ResetSel);
            pend_q        <= '0;
            cnt_q         <= '0;
            gcnt_q        <= '0;
            switch_done_o <= 1'b0;
            err_sel_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_active_o  <= sel_d;
            pend_q        <= pend_d;
            cnt_q         <= cnt_d;
            gcnt_q        <= gcnt_d;
            switch_done_o <= done_d;
            err_sel_o     <= err_d;
        end
    end
    // next-state: accept requests, wait for an idle bus, then hold the guard
    always_comb begin
        state_d = state_q;
        sel_d   = sel_active_o;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ACTIVE: if (accept) begin
                if (bad_sel) err_d = 1'b1;
                else if (sel_req_i == sel_active_o) done_d = 1'b1;
                else begin
                    pend_d  = sel_req_i;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                    state_d = force_en ? GUARD : WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                cnt_d = !bus_idle ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
                if (cnt_q >= t_bus_free_i) begin
                    state_d = GUARD;
                    gcnt_d  = '0;
                end
            end
            GUARD: begin
                gcnt_d = gcnt_q + 8'd1;
                if (gcnt_q == guard_last) begin
                    state_d = ACTIVE;
                    sel_d   = pend_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end
    // routing: the selected channel owns the PHY except during the guard, where the bus is released
    always_comb begin
        scl_o       = 1'b1;
        sda_o       = 1'b1;
        sel_od_pp_o = 1'b0;
        ctrl_scl_o  = '1;
        ctrl_sda_o  = '1;
        for (int i = 0; i < NumCtrl; i++) begin
            if (state_q != GUARD && sel_active_o == SelW'(i)) begin
                scl_o         = ctrl_scl_i[i];
                sda_o         = ctrl_sda_i[i];
                sel_od_pp_o   = ctrl_sel_od_pp_i[i];
                ctrl_scl_o[i] = scl_i;
                ctrl_sda_o[i] = sda_i;
            end
        end
    end
endmodule

// File: tb/tb_phy_ctrl_mux.sv
// tb_phy_ctrl_mux: randomized bench for phy_ctrl_mux; predicts each switch by scanning the scripted bus pattern for the idle run
module tb_phy_ctrl_mux;
    localparam int N = 4, SW = 3, TW = 8, G = 4, RS = 0;
    logic          clk_i = 1'b0, rst_i = 1'b1;
    logic          scl_i, sda_i, scl_o, sda_o, sel_od_pp_o;
    logic [N-1:0]  ctrl_scl_o, ctrl_sda_o, ctrl_scl_i, ctrl_sda_i, ctrl_sel_od_pp_i;
    logic [SW-1:0] sel_req_i, sel_active_o;
    logic          sel_req_valid_i, sel_req_ready_o, switching_o, switch_done_o, err_sel_o;
    logic [TW-1:0] t_bus_free_i;
    int            total = 0, bad = 0, cur = RS;
    bit            idle_a[0:199];
    int            t_a[0:199];

    always #5 clk_i = ~clk_i;

    phy_ctrl_mux #(.NumCtrl(N), .SelW(SW), .TimerW(TW), .GuardCycles(G), .ResetSel(RS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i),
        .scl_o(scl_o), .sda_o(sda_o), .sel_od_pp_o(sel_od_pp_o),
        .ctrl_scl_o(ctrl_scl_o), .ctrl_sda_o(ctrl_sda_o),
        .ctrl_scl_i(ctrl_scl_i), .ctrl_sda_i(ctrl_sda_i), .ctrl_sel_od_pp_i(ctrl_sel_od_pp_i),
        .sel_req_i(sel_req_i), .sel_req_valid_i(sel_req_valid_i), .sel_req_ready_o(sel_req_ready_o),
        .t_bus_free_i(t_bus_free_i), .sel_active_o(sel_active_o), .switching_o(switching_o),
        .switch_done_o(switch_done_o), .err_sel_o(err_sel_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // drive the bus sample and random channel drive for one cycle
    task automatic drive_bus(input bit idle);
        logic [1:0] v;
        v = 2'($urandom_range(0, 2));
        {scl_i, sda_i} = idle ? 2'b11 : v;
        ctrl_scl_i = N'($urandom);
        ctrl_sda_i = N'($urandom);
        ctrl_sel_od_pp_i = N'($urandom);
    endtask

    // check every output for one cycle given the expected phase
    task automatic chk_cycle(input bit sw, input bit guard, input int a, input bit done, input bit err);
        logic [N-1:0] es, ed;
        es = '1;
        ed = '1;
        if (!guard) begin
            es[a] = scl_i;
            ed[a] = sda_i;
        end
        chk("sel_active", sel_active_o, a);
        chk("switching", switching_o, sw);
        chk("ready", sel_req_ready_o, !sw);
        chk("done", switch_done_o, done);
        chk("err", err_sel_o, err);
        chk("scl_o", scl_o, guard ? 1'b1 : ctrl_scl_i[a]);
        chk("sda_o", sda_o, guard ? 1'b1 : ctrl_sda_i[a]);
        chk("od_pp", sel_od_pp_o, guard ? 1'b0 : ctrl_sel_od_pp_i[a]);
        chk("ctrl_scl_o", ctrl_scl_o, es);
        chk("ctrl_sda_o", ctrl_sda_o, ed);
    endtask

    // one request at cycle 0; hold keeps valid high while switching; rg>=0 resets rg cycles into the guard
    task automatic run_switch(input int tgt, input bit hold, input int rg);
        int g = 0, run = 0, last;
        bit bad_sel, same, swp;
        bad_sel = tgt >= N;
        same = tgt == cur;
        swp = !bad_sel && !same;
        if (swp) begin
            for (int k = 1; k < 190; k++) begin
                if (run >= t_a[k]) begin
                    g = k + 1;
                    break;
                end
                run = idle_a[k] ? run + 1 : 0;
            end
            if (g == 0) chk("model_no_exit", 0, 1);
        end
        last = swp ? g + G : 2;
        for (int c = 0; c <= last; c++) begin
            sel_req_valid_i = c == 0 || (swp && hold && c < last);
            sel_req_i = c == 0 ? SW'(tgt) : SW'($urandom);
            t_bus_free_i = TW'(t_a[c]);
            rst_i = swp && rg >= 0 && c == g + rg;
            drive_bus(idle_a[c]);
            @(negedge clk_i);
            if (swp) chk_cycle(c >= 1 && c < last, c >= g && c < last, c >= last ? tgt : cur, c == last, 1'b0);
            else chk_cycle(1'b0, 1'b0, cur, same && c == 1, bad_sel && c == 1);
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                rst_i = 1'b0;
                sel_req_valid_i = 1'b0;
                drive_bus(1'b1);
                @(negedge clk_i);
                chk_cycle(1'b0, 1'b0, RS, 1'b0, 1'b0);
                @(posedge clk_i);
                #1;
                cur = RS;
                return;
            end
        end
        sel_req_valid_i = 1'b0;
        if (swp) cur = tgt;
    endtask

    task automatic fill(input int t, input int idle_pct);
        for (int k = 0; k < 200; k++) begin
            t_a[k] = t;
            idle_a[k] = k >= 40 || $urandom_range(0, 99) < idle_pct;
        end
    endtask

    initial begin
        sel_req_valid_i = 1'b0;
        sel_req_i = '0;
        t_bus_free_i = '0;
        drive_bus(1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_cycle(1'b0, 1'b0, RS, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        fill(10, 100);
        run_switch(2, 1'b0, -1);
        fill(5, 100);
        idle_a[4] = 1'b0;
        run_switch(1, 1'b0, -1);
        fill(0, 100);
        run_switch(7, 1'b0, -1);
        run_switch(1, 1'b0, -1);
        run_switch(0, 1'b0, -1);
        fill(3, 100);
        run_switch(3, 1'b1, -1);
        fill(2, 100);
        run_switch(2, 1'b0, 1);
        fill(6, 100);
        for (int k = 4; k < 200; k++) t_a[k] = 1;
        run_switch(1, 1'b0, -1);
        for (int i = 0; i < 40; i++) begin
            fill($urandom_range(0, 5), 85);
            if ($urandom_range(0, 3) == 0) for (int k = $urandom_range(1, 6); k < 200; k++) t_a[k] = $urandom_range(0, 5);
            run_switch($urandom_range(0, 7), 1'($urandom), ($urandom_range(0, 9) == 0) ? $urandom_range(0, G - 1) : -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/phy_ctrl_mux.md
PHY_CTRL_MUX -- requirements
Module: phy_ctrl_mux

Interface
REQ-001 SHALL have parameter NumCtrl, default 4, number of controller channels sharing one PHY (range 2..16).
REQ-002 SHALL have parameter SelW, default $clog2(NumCtrl), select width.
REQ-003 SHALL have parameter TimerW, default 20, bus-free timer width.
REQ-004 SHALL have parameter GuardCycles, default 4, released-bus cycles inserted at switchover (range 1..255).
REQ-005 SHALL have parameter ResetSel, default 0, channel selected out of reset.
REQ-006 SHALL have ports clk_i in 1, the single clock; rst_i in 1, reset, synchronous and active-high.
REQ-007 SHALL have ports scl_i in 1 and sda_i in 1, the PHY bus sample.
REQ-008 SHALL have ports scl_o out 1, sda_o out 1 and sel_od_pp_o out 1, driven to the PHY.
REQ-009 SHALL have ports ctrl_scl_o out NumCtrl and ctrl_sda_o out NumCtrl, per-channel bus view.
REQ-010 SHALL have ports ctrl_scl_i in NumCtrl, ctrl_sda_i in NumCtrl and ctrl_sel_od_pp_i in NumCtrl, per-channel drive.
REQ-011 SHALL have ports sel_req_i in SelW, sel_req_valid_i in 1 and sel_req_ready_o out 1, the switch request handshake.
REQ-012 SHALL have ports t_bus_free_i in TimerW, required idle cycles before switchover.
REQ-013 SHALL have ports sel_active_o out SelW, switching_o out 1, switch_done_o out 1 (pulse) and err_sel_o out 1 (pulse).

Function
REQ-014 SHALL implement FSM states ACTIVE, WAIT_FREE and GUARD.
REQ-015 In ACTIVE: scl_o/sda_o/sel_od_pp_o = ctrl_*_i[sel_active_o]; ctrl_scl_o/ctrl_sda_o[sel_active_o] = scl_i/sda_i; all other channels see 1/1.
REQ-016 sel_req_ready_o SHALL be 1 only in ACTIVE; a request is accepted when valid && ready.
REQ-017 Accepted sel_req_i >= NumCtrl: err_sel_o pulses 1 cycle, request dropped, stay ACTIVE.
REQ-018 Accepted sel_req_i == sel_active_o: switch_done_o pulses next cycle, stay ACTIVE.
REQ-019 Otherwise: store pending select, enter WAIT_FREE, clear idle counter to 0.
REQ-020 WAIT_FREE: routing per REQ-015 with current channel; counter +1 (saturating at all-ones) on cycles with scl_i=1 && sda_i=1, cleared to 0 otherwise.
REQ-021 WAIT_FREE SHALL exit to GUARD in the cycle after counter >= t_bus_free_i is observed; t_bus_free_i=0 gives exactly one WAIT_FREE cycle.
REQ-022 GUARD: scl_o=1, sda_o=1, sel_od_pp_o=0; all channels see 1/1; lasts exactly GuardCycles cycles.
REQ-023 On leaving GUARD: sel_active_o <= pending, state ACTIVE, switch_done_o pulses 1 cycle in the first ACTIVE cycle.
REQ-024 switching_o SHALL be 1 in WAIT_FREE and GUARD, else 0.
REQ-025 t_bus_free_i SHALL be sampled live each cycle; a change mid-WAIT_FREE takes effect immediately.
REQ-026 Latency: request accepted in cycle N, bus idle throughout, gives new channel ACTIVE in cycle N+2+T+GuardCycles (T = t_bus_free_i).

Reset
REQ-027 While rst_i=1 at a clk_i edge: state ACTIVE, sel_active_o=ResetSel, counters 0, pending cleared.
REQ-028 After that edge: switching_o=0, switch_done_o=0, err_sel_o=0, sel_req_ready_o=1.
REQ-029 Reset asserted in WAIT_FREE or GUARD SHALL abort the switch; pending is discarded.

Configuration
REQ-030 Macro PHY_CTRL_MUX_FORCE_SW_EN defined: port force_sw_i in 1 is added; a request accepted with force_sw_i=1 bypasses WAIT_FREE and enters GUARD directly (latency N+1+GuardCycles).
REQ-031 Macro undefined: no force_sw_i port; every switch passes through WAIT_FREE.

Verification
REQ-032 Reset with ResetSel=0 -> sel_active_o=0, ready=1, scl_o follows ctrl_scl_i[0]; channels 1-3 see 1/1.
REQ-033 Request sel=2, T=10, GuardCycles=4, bus idle, accepted cycle 0 -> GUARD cycles 12-15 with scl_o=sda_o=1 and od_pp=0; sel_active_o=2 and switch_done_o pulse in cycle 16.
REQ-034 Request sel=1, T=5, sda_i low at WAIT_FREE cycle 3 -> counter restarts; GUARD entry delayed by 4 cycles versus idle bus.
REQ-035 Request sel=7 with NumCtrl=4 -> err_sel_o pulse, sel_active_o unchanged, no switching_o.
REQ-036 Valid held high during switching -> ready=0, no second capture; rst_i in GUARD -> sel_active_o=ResetSel next cycle.
REQ-037 With PHY_CTRL_MUX_FORCE_SW_EN, force_sw_i=1, sel=3, T=100 -> sel_active_o=3 in cycle 1+GuardCycles.
